// File: rtl/i2c_pkg.sv
// Shared state encoding and bus-level constants for the I2C target register file.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_filter.sv
// Two-flop synchroniser followed by a stability filter; emits one-cycle edge pulses
// of the filtered level. Idle bus level is high, so everything resets to 1.
module i2c_sync_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          s1_q, s2_q, filt_q, filt_d, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (s2_q != filt_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) filt_d = s2_q;
      else                            cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      prev_q <= filt_q;
      cnt_q  <= cnt_d;
    end
  end

  assign q_o    = filt_q;
  assign rise_o = filt_q & ~prev_q;
  assign fall_o = ~filt_q & prev_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing NUM_REGS byte registers with pointer-addressed burst
// writes/reads, auto-increment with wrap, and optional SCL stretching.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h42,
  parameter int         NUM_REGS   = 8,
  parameter int         FILT_LEN   = 3,
  parameter int         STRETCH_EN = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        scl_oe,
  output logic                        sda_oe,
  input  logic                        stretch_req,
  output logic [NUM_REGS*8-1:0]       regs_o,
  output logic                        wr_stb,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx,
  output logic                        busy
);

  localparam int PW = $clog2(NUM_REGS);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_REGS - 1)) ? '0 : p + 1'b1;
  endfunction

  logic scl_f, scl_rise, scl_fall, sda_f, sda_rise, sda_fall;
  logic start, stop;

  i2c_sync_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk(clk), .rst(rst), .d_i(scl_i), .q_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
  );
  i2c_sync_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk(clk), .rst(rst), .d_i(sda_i), .q_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start = sda_fall & scl_f;
  assign stop  = sda_rise & scl_f;

  i2c_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_nxt, wr_idx_q, wr_idx_d;
  logic          ack_q, ack_d, rw_q, rw_d;
  logic          sda_oe_q, sda_oe_d, stretch_q, stretch_d, busy_q, busy_d;
  logic          wr_stb_q, wr_stb_d, we;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    byte_in, rd_cur, rd_nxt;

  assign byte_in = {sh_q[6:0], sda_f};
  assign ptr_nxt = ptr_inc(ptr_q);
  assign rd_cur  = regs_q[ptr_q];
  assign rd_nxt  = regs_q[ptr_nxt];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    ack_d     = ack_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    stretch_d = stretch_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    we        = 1'b0;

    if (stretch_q && !stretch_req) stretch_d = 1'b0;

    // Data-byte commit is independent of bus events so a coincident START cannot drop it.
    if (state_q == WDATA && scl_rise && cnt_q == 4'd7) begin
      we       = 1'b1;
      wr_stb_d = 1'b1;
      wr_idx_d = ptr_q;
      ptr_d    = ptr_nxt;
    end

    if (stop) begin
      state_d   = IDLE;
      cnt_d     = '0;
      sda_oe_d  = 1'b0;
      stretch_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (byte_in[7:1] == DEV_ADDR) begin
              state_d = ADDR_ACK;
              ack_d   = I2C_ACK;
              rw_d    = byte_in[0];
              busy_d  = 1'b1;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
              busy_d  = 1'b0;
            end
          end
        end
        PTR: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d = PTR_ACK;
            if (int'(byte_in) < NUM_REGS) begin
              ptr_d = byte_in[PW-1:0];
              ack_d = I2C_ACK;
            end else begin
              ack_d = I2C_NACK;
            end
          end
        end
        WDATA: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d = WDATA_ACK;
            ack_d   = I2C_ACK;
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            sda_oe_d = (ack_q == I2C_ACK);
            cnt_d    = 4'd9;
          end else begin
            // Falling edge closing the ACK/NACK slot: the only point where stretching may begin.
            sda_oe_d  = 1'b0;
            cnt_d     = '0;
            stretch_d = (STRETCH_EN != 0) && stretch_req;
            if (state_q == ADDR_ACK) begin
              if (rw_q) begin
                state_d  = RDATA;
                sh_d     = rd_cur;
                sda_oe_d = ~rd_cur[7];
              end else begin
                state_d = PTR;
              end
            end else if (state_q == PTR_ACK && ack_q == I2C_NACK) begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end else begin
              state_d = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = RDATA_ACK;
            end else begin
              sh_d     = sh_q << 1;
              sda_oe_d = ~sh_q[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            ack_d = sda_f;
            cnt_d = 4'd9;
          end else if (scl_fall && cnt_q == 4'd9) begin
            cnt_d     = '0;
            stretch_d = (STRETCH_EN != 0) && stretch_req;
            if (ack_q == I2C_ACK) begin
              ptr_d    = ptr_nxt;
              sh_d     = rd_nxt;
              sda_oe_d = ~rd_nxt[7];
              state_d  = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
              state_d  = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      ptr_q     <= '0;
      ack_q     <= I2C_NACK;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      stretch_q <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      stretch_q <= stretch_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[ptr_q] <= byte_in;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[8*g +: 8] = regs_q[g];
  end

  assign scl_oe = stretch_q;
  assign sda_oe = sda_oe_q;
  assign wr_stb = wr_stb_q;
  assign wr_idx = wr_idx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: a bit-banged I2C host on an open-drain bus exercises the register file target.
`timescale 1ns/1ps
module tb_i2c_target_regfile;

  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          scl_m = 1'b1, sda_m = 1'b1, stretch_req = 1'b0;
  logic          scl_oe, sda_oe, wr_stb, busy;
  logic [NR*8-1:0] regs_o;
  logic [2:0]    wr_idx;
  wire           scl_line;
  wire           sda_line;
  assign scl_line = scl_m & ~scl_oe;
  assign sda_line = sda_m & ~sda_oe;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_regs [NR];
  int         log_idx [$];

  i2c_target_regfile dut (
    .clk(clk), .rst(rst), .scl_i(scl_line), .sda_i(sda_line),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .stretch_req(stretch_req),
    .regs_o(regs_o), .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_stb === 1'b1) log_idx.push_back(int'(wr_idx));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [NR*8-1:0] exp_vec();
    logic [NR*8-1:0] v;
    for (int i = 0; i < NR; i++) v[8*i +: 8] = exp_regs[i];
    return v;
  endfunction

  function automatic int log_at(input int i);
    return (i < log_idx.size()) ? log_idx[i] : -1;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scl_high();
    int t;
    t = 0;
    scl_m = 1'b1;
    while (scl_line !== 1'b1 && t < 500) begin
      wait_clk(1);
      t++;
    end
    if (scl_line !== 1'b1) begin
      checks++; errors++;
      $display("FAIL scl_release: scl line %b after %0d cycles, required 1", scl_line, t);
    end
  endtask

  task automatic clk_bit(input logic b, output logic r);
    sda_m = b;
    wait_clk(5);
    scl_high();
    wait_clk(5);
    r = sda_line;
    wait_clk(5);
    scl_m = 1'b0;
    wait_clk(5);
  endtask

  task automatic start_cond();
    sda_m = 1'b1;
    wait_clk(5);
    scl_high();
    wait_clk(5);
    sda_m = 1'b0;
    wait_clk(5);
    scl_m = 1'b0;
    wait_clk(5);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0;
    wait_clk(5);
    scl_high();
    wait_clk(5);
    sda_m = 1'b1;
    wait_clk(10);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      d[i] = r;
    end
    clk_bit(mack, r);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) exp_regs[i] = 8'h00;
    wait_clk(3);
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL reset_scl_oe: got %b want 0", scl_oe); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL reset_wr_stb: got %b want 0", wr_stb); end
    checks++; if (wr_idx !== 3'd0) begin errors++; $display("FAIL reset_wr_idx: got %0d want 0", wr_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (regs_o !== '0) begin errors++; $display("FAIL reset_regs: got %h want 0", regs_o); end
    rst = 1'b0;
    wait_clk(10);
  endtask

  task automatic test_write_burst();
    logic [7:0] wb [4];
    logic a;
    wb = '{8'h84, 8'h03, 8'hA5, 8'h5A};
    log_idx.delete();
    start_cond();
    for (int i = 0; i < 4; i++) begin
      write_byte(wb[i], a);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_ack%0d: got %b want 0", i, a); end
      if (i == 0) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_on: got %b want 1", busy); end
      end
    end
    stop_cond();
    exp_regs[3] = 8'hA5;
    exp_regs[4] = 8'h5A;
    checks++; if (log_idx.size() != 2) begin errors++; $display("FAIL wr_stb_count: got %0d want 2", log_idx.size()); end
    checks++; if (log_at(0) != 3) begin errors++; $display("FAIL wr_idx0: got %0d want 3", log_at(0)); end
    checks++; if (log_at(1) != 4) begin errors++; $display("FAIL wr_idx1: got %0d want 4", log_at(1)); end
    checks++; if (regs_o !== exp_vec()) begin errors++; $display("FAIL wr_regs: got %h want %h", regs_o, exp_vec()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_off: got %b want 0", busy); end
  endtask

  task automatic test_read_wrap();
    logic [7:0] wb [4];
    logic [7:0] d;
    logic a;
    wb = '{8'h84, 8'h07, 8'h11, 8'h22};
    start_cond();
    for (int i = 0; i < 4; i++) begin
      write_byte(wb[i], a);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL preload_ack%0d: got %b want 0", i, a); end
    end
    stop_cond();
    exp_regs[7] = 8'h11;
    exp_regs[0] = 8'h22;
    checks++; if (regs_o !== exp_vec()) begin errors++; $display("FAIL preload_regs: got %h want %h", regs_o, exp_vec()); end
    log_idx.delete();
    start_cond();
    write_byte(8'h84, a);
    write_byte(8'h07, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL rd_ptr_ack: got %b want 0", a); end
    start_cond();
    write_byte(8'h85, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b want 0", a); end
    read_byte(1'b0, d);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL rd_byte0: got %h want 11", d); end
    read_byte(1'b1, d);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL rd_byte1: got %h want 22", d); end
    wait_clk(3);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_sda_release: got %b want 0", sda_oe); end
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL rd_scl_release: got %b want 0", scl_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_ignore: got %b want 0", busy); end
    stop_cond();
    checks++; if (log_idx.size() != 0) begin errors++; $display("FAIL rd_no_wr_stb: got %0d want 0", log_idx.size()); end
  endtask

  task automatic test_addr_mismatch();
    logic a;
    log_idx.delete();
    start_cond();
    write_byte(8'h86, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL mm_addr_nack: got %b want 1", a); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mm_busy: got %b want 0", busy); end
    write_byte(8'h01, a);
    write_byte(8'h99, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL mm_data_nack: got %b want 1", a); end
    stop_cond();
    checks++; if (log_idx.size() != 0) begin errors++; $display("FAIL mm_no_wr_stb: got %0d want 0", log_idx.size()); end
    checks++; if (regs_o !== exp_vec()) begin errors++; $display("FAIL mm_regs: got %h want %h", regs_o, exp_vec()); end
    start_cond();
    write_byte(8'h84, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL mm_next_ack: got %b want 0", a); end
    write_byte(8'h01, a);
    write_byte(8'h77, a);
    stop_cond();
    exp_regs[1] = 8'h77;
    checks++; if (regs_o !== exp_vec()) begin errors++; $display("FAIL mm_next_regs: got %h want %h", regs_o, exp_vec()); end
    checks++; if (log_at(0) != 1) begin errors++; $display("FAIL mm_next_idx: got %0d want 1", log_at(0)); end
  endtask

  task automatic test_bad_ptr();
    logic a;
    log_idx.delete();
    start_cond();
    write_byte(8'h84, a);
    write_byte(8'h08, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL bp_ptr_nack: got %b want 1", a); end
    write_byte(8'hFF, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL bp_data_nack: got %b want 1", a); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy: got %b want 0", busy); end
    stop_cond();
    checks++; if (log_idx.size() != 0) begin errors++; $display("FAIL bp_no_wr_stb: got %0d want 0", log_idx.size()); end
    checks++; if (regs_o !== exp_vec()) begin errors++; $display("FAIL bp_regs: got %h want %h", regs_o, exp_vec()); end
  endtask

  task automatic test_stretch();
    logic a, r;
    logic [7:0] b;
    log_idx.delete();
    b = 8'h3C;
    start_cond();
    write_byte(8'h84, a);
    write_byte(8'h05, a);
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL st_no_early: got %b want 0", scl_oe); end
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    stretch_req = 1'b1;
    sda_m = 1'b1;
    wait_clk(5);
    scl_high();
    wait_clk(5);
    a = sda_line;
    wait_clk(5);
    scl_m = 1'b0;
    wait_clk(8);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL st_data_ack: got %b want 0", a); end
    checks++; if (scl_oe !== 1'b1) begin errors++; $display("FAIL st_assert: got %b want 1", scl_oe); end
    wait_clk(20);
    checks++; if (scl_oe !== 1'b1) begin errors++; $display("FAIL st_hold: got %b want 1", scl_oe); end
    stretch_req = 1'b0;
    #1;
    checks++; if (scl_oe !== 1'b1) begin errors++; $display("FAIL st_same_cycle: got %b want 1", scl_oe); end
    wait_clk(1);
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL st_release: got %b want 0", scl_oe); end
    write_byte(8'hC3, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL st_next_ack: got %b want 0", a); end
    stop_cond();
    exp_regs[5] = 8'h3C;
    exp_regs[6] = 8'hC3;
    checks++; if (regs_o !== exp_vec()) begin errors++; $display("FAIL st_regs: got %h want %h", regs_o, exp_vec()); end
    checks++; if (log_at(0) != 5 || log_at(1) != 6 || log_idx.size() != 2)
      begin errors++; $display("FAIL st_idx: got %0d,%0d (n=%0d) want 5,6 (n=2)", log_at(0), log_at(1), log_idx.size()); end
  endtask

  task automatic test_glitch();
    logic a;
    wait_clk(5);
    sda_m = 1'b0;
    wait_clk(2);
    sda_m = 1'b1;
    wait_clk(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gl_busy_after_glitch: got %b want 0", busy); end
    scl_m = 1'b0;
    wait_clk(5);
    write_byte(8'h84, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL gl_no_start_ack: got %b want 1", a); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gl_busy: got %b want 0", busy); end
    stop_cond();
  endtask

  task automatic test_reset_mid_read();
    logic a;
    start_cond();
    write_byte(8'h85, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL rr_addr_ack: got %b want 0", a); end
    wait_clk(3);
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rr_driving: got %b want 1", sda_oe); end
    rst = 1'b1;
    #1;
    for (int i = 0; i < NR; i++) exp_regs[i] = 8'h00;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rr_sda_oe: got %b want 0", sda_oe); end
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL rr_scl_oe: got %b want 0", scl_oe); end
    checks++; if (regs_o !== exp_vec()) begin errors++; $display("FAIL rr_regs: got %h want 0", regs_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy: got %b want 0", busy); end
    wait_clk(2);
    rst = 1'b0;
    sda_m = 1'b1;
    scl_m = 1'b1;
    wait_clk(20);
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_wrap();
    test_addr_mismatch();
    test_bad_ptr();
    test_stretch();
    test_glitch();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
